// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the bus datapath: instruction/handshake inputs and every strobe.
// master = sequencer (drives strobes); slave = datapath (drives run_req, mem_ready, IR_Data).
interface control_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5,
  parameter int RSEL_W = 4
);
  logic              run_req;
  logic              mem_ready;
  logic [DATA_W-1:0] IR_Data;

  logic              PC_select;
  logic              Z_LO_select;
  logic              Z_HI_select;
  logic              MDR_select;
  logic              PC_enable;
  logic              PC_increment_enable;
  logic              IR_enable;
  logic              MAR_enable;
  logic              MDR_enable;
  logic              Y_enable;
  logic              Z_enable;
  logic              HI_enable;
  logic              LO_enable;
  logic              read;
  logic              reg_out_en;
  logic [RSEL_W-1:0] reg_out_sel;
  logic              reg_in_en;
  logic [RSEL_W-1:0] reg_in_sel;
  logic [OPC_W-1:0]  alu_instruction;
  logic              run;
  logic              illegal_op;
  logic [3:0]        state_dbg;

  modport master (
    input  run_req, mem_ready, IR_Data,
    output PC_select, Z_LO_select, Z_HI_select, MDR_select,
           PC_enable, PC_increment_enable, IR_enable, MAR_enable, MDR_enable,
           Y_enable, Z_enable, HI_enable, LO_enable, read,
           reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
           alu_instruction, run, illegal_op, state_dbg
  );

  modport slave (
    output run_req, mem_ready, IR_Data,
    input  PC_select, Z_LO_select, Z_HI_select, MDR_select,
           PC_enable, PC_increment_enable, IR_enable, MAR_enable, MDR_enable,
           Y_enable, Z_enable, HI_enable, LO_enable, read,
           reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
           alu_instruction, run, illegal_op, state_dbg
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control unit: fetch T0-T2 (T1 stretched by mem_ready), execute T3-T6; strobes are decoded from state + IR.
// Latency 4-7 cycles per instruction plus memory wait cycles; run_req only sampled at instruction boundaries.
module control_sequencer #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5,
  parameter int RSEL_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  control_sequencer_if.master cs
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_TWO, C_ONE, C_WIDE, C_NOP, C_HALT, C_UNDEF
  } cls_t;

  state_t            state, state_nxt;
  logic              t1_first;
  cls_t              cls;
  logic [OPC_W-1:0]  opc;
  logic [RSEL_W-1:0] ra, rb, rc;

  assign opc = cs.IR_Data[DATA_W-1 -: OPC_W];
  assign ra  = cs.IR_Data[DATA_W-OPC_W-1 -: RSEL_W];
  assign rb  = cs.IR_Data[DATA_W-OPC_W-RSEL_W-1 -: RSEL_W];
  assign rc  = cs.IR_Data[DATA_W-OPC_W-2*RSEL_W-1 -: RSEL_W];

  always_comb begin
    cls = C_UNDEF;
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: cls = C_TWO;
      5'b10001, 5'b10010:                     cls = C_ONE;
      5'b01111, 5'b10000:                     cls = C_WIDE;
      5'b11010:                               cls = C_NOP;
      5'b11011:                               cls = C_HALT;
      default:                                cls = C_UNDEF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      t1_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      // PC_enable must fire once per fetch even when T1 is stretched
      t1_first <= (state == S_T0);
    end
  end

  always_comb begin
    state_t bnd;
    bnd       = cs.run_req ? S_T0 : S_IDLE;
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = cs.run_req ? S_T0 : S_IDLE;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = cs.mem_ready ? S_T2 : S_T1;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        case (cls)
          C_TWO, C_ONE, C_WIDE: state_nxt = S_T4;
          C_HALT:               state_nxt = S_HALT;
          default:              state_nxt = bnd;
        endcase
      end
      S_T4:   state_nxt = (cls == C_TWO || cls == C_WIDE) ? S_T5 : bnd;
      S_T5:   state_nxt = (cls == C_WIDE) ? S_T6 : bnd;
      S_T6:   state_nxt = bnd;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs.PC_select           = 1'b0;
    cs.Z_LO_select         = 1'b0;
    cs.Z_HI_select         = 1'b0;
    cs.MDR_select          = 1'b0;
    cs.PC_enable           = 1'b0;
    cs.PC_increment_enable = 1'b0;
    cs.IR_enable           = 1'b0;
    cs.MAR_enable          = 1'b0;
    cs.MDR_enable          = 1'b0;
    cs.Y_enable            = 1'b0;
    cs.Z_enable            = 1'b0;
    cs.HI_enable           = 1'b0;
    cs.LO_enable           = 1'b0;
    cs.read                = 1'b0;
    cs.reg_out_en          = 1'b0;
    cs.reg_out_sel         = '0;
    cs.reg_in_en           = 1'b0;
    cs.reg_in_sel          = '0;
    cs.alu_instruction     = '0;
    cs.illegal_op          = 1'b0;
    cs.run                 = (state != S_IDLE) && (state != S_HALT);
    cs.state_dbg           = state;
    case (state)
      S_T0: begin
        cs.PC_select           = 1'b1;
        cs.MAR_enable          = 1'b1;
        cs.PC_increment_enable = 1'b1;
        cs.Z_enable            = 1'b1;
      end
      S_T1: begin
        cs.Z_LO_select = 1'b1;
        cs.PC_enable   = t1_first;
        cs.read        = 1'b1;
        cs.MDR_enable  = 1'b1;
      end
      S_T2: begin
        cs.MDR_select = 1'b1;
        cs.IR_enable  = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_TWO: begin
            cs.reg_out_en  = 1'b1;
            cs.reg_out_sel = rb;
            cs.Y_enable    = 1'b1;
          end
          C_ONE: begin
            cs.reg_out_en      = 1'b1;
            cs.reg_out_sel     = rb;
            cs.alu_instruction = opc;
            cs.Z_enable        = 1'b1;
          end
          C_WIDE: begin
            cs.reg_out_en  = 1'b1;
            cs.reg_out_sel = ra;
            cs.Y_enable    = 1'b1;
          end
          C_UNDEF: cs.illegal_op = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_TWO: begin
            cs.reg_out_en      = 1'b1;
            cs.reg_out_sel     = rc;
            cs.alu_instruction = opc;
            cs.Z_enable        = 1'b1;
          end
          C_ONE: begin
            cs.Z_LO_select = 1'b1;
            cs.reg_in_en   = 1'b1;
            cs.reg_in_sel  = ra;
          end
          C_WIDE: begin
            cs.reg_out_en      = 1'b1;
            cs.reg_out_sel     = rb;
            cs.alu_instruction = opc;
            cs.Z_enable        = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        if (cls == C_TWO) begin
          cs.Z_LO_select = 1'b1;
          cs.reg_in_en   = 1'b1;
          cs.reg_in_sel  = ra;
        end else if (cls == C_WIDE) begin
          cs.Z_LO_select = 1'b1;
          cs.LO_enable   = 1'b1;
        end
      end
      S_T6: begin
        cs.Z_HI_select = 1'b1;
        cs.HI_enable   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized instruction stream checked cycle-by-cycle against a per-instruction micro-step model.
// Stimulus pushes the expected control word per cycle; a negedge monitor pops and compares.
module tb_control_sequencer;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_sel, zlo_sel, zhi_sel, mdr_sel;
    logic       pc_en, pc_inc, ir_en, mar_en, mdr_en, y_en, z_en, hi_en, lo_en, rd;
    logic       ro_en;
    logic [3:0] ro_sel;
    logic       ri_en;
    logic [3:0] ri_sel;
    logic [4:0] alu;
    logic       run, ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t plan[$];
  bit   plan_mr[$];

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t s;
    s.st      = bus.state_dbg;
    s.pc_sel  = bus.PC_select;
    s.zlo_sel = bus.Z_LO_select;
    s.zhi_sel = bus.Z_HI_select;
    s.mdr_sel = bus.MDR_select;
    s.pc_en   = bus.PC_enable;
    s.pc_inc  = bus.PC_increment_enable;
    s.ir_en   = bus.IR_enable;
    s.mar_en  = bus.MAR_enable;
    s.mdr_en  = bus.MDR_enable;
    s.y_en    = bus.Y_enable;
    s.z_en    = bus.Z_enable;
    s.hi_en   = bus.HI_enable;
    s.lo_en   = bus.LO_enable;
    s.rd      = bus.read;
    s.ro_en   = bus.reg_out_en;
    s.ro_sel  = bus.reg_out_sel;
    s.ri_en   = bus.reg_in_en;
    s.ri_sel  = bus.reg_in_sel;
    s.alu     = bus.alu_instruction;
    s.run     = bus.run;
    s.ill     = bus.illegal_op;
    return s;
  endfunction

  task automatic chk(input string nm, input exp_t act, input exp_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) chk("cycle", sample(), sb.pop_front());
  end

  function automatic exp_t rec(input logic [3:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.run = (st != 4'd0) && (st != 4'd8);
    return e;
  endfunction

  function automatic exp_t ro(input exp_t e_in, input logic [3:0] r);
    exp_t e;
    e        = e_in;
    e.ro_en  = 1'b1;
    e.ro_sel = r;
    return e;
  endfunction

  function automatic exp_t ri(input exp_t e_in, input logic [3:0] r);
    exp_t e;
    e        = e_in;
    e.ri_en  = 1'b1;
    e.ri_sel = r;
    return e;
  endfunction

  task automatic add(input exp_t e, input bit mr);
    plan.push_back(e);
    plan_mr.push_back(mr);
  endtask

  // Expected control words for one instruction: fetch with w memory wait cycles, then the class's micro-steps.
  task automatic build(input logic [31:0] ir, input int w);
    exp_t e;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    opc = ir[31:27];
    ra  = ir[26:23];
    rb  = ir[22:19];
    rc  = ir[18:15];
    plan.delete();
    plan_mr.delete();
    e = rec(4'd1); e.pc_sel = 1; e.mar_en = 1; e.pc_inc = 1; e.z_en = 1;
    add(e, 1'($urandom_range(0, 1)));
    for (int i = 0; i <= w; i++) begin
      e = rec(4'd2); e.zlo_sel = 1; e.rd = 1; e.mdr_en = 1; e.pc_en = (i == 0);
      add(e, i == w);
    end
    e = rec(4'd3); e.mdr_sel = 1; e.ir_en = 1;
    add(e, 1'($urandom_range(0, 1)));
    if (opc inside {[5'd3:5'd10]}) begin
      e = ro(rec(4'd4), rb); e.y_en = 1; add(e, 1'($urandom_range(0, 1)));
      e = ro(rec(4'd5), rc); e.alu = opc; e.z_en = 1; add(e, 1'($urandom_range(0, 1)));
      e = ri(rec(4'd6), ra); e.zlo_sel = 1; add(e, 1'($urandom_range(0, 1)));
    end else if (opc == 5'd17 || opc == 5'd18) begin
      e = ro(rec(4'd4), rb); e.alu = opc; e.z_en = 1; add(e, 1'($urandom_range(0, 1)));
      e = ri(rec(4'd5), ra); e.zlo_sel = 1; add(e, 1'($urandom_range(0, 1)));
    end else if (opc == 5'd15 || opc == 5'd16) begin
      e = ro(rec(4'd4), ra); e.y_en = 1; add(e, 1'($urandom_range(0, 1)));
      e = ro(rec(4'd5), rb); e.alu = opc; e.z_en = 1; add(e, 1'($urandom_range(0, 1)));
      e = rec(4'd6); e.zlo_sel = 1; e.lo_en = 1; add(e, 1'($urandom_range(0, 1)));
      e = rec(4'd7); e.zhi_sel = 1; e.hi_en = 1; add(e, 1'($urandom_range(0, 1)));
    end else if (opc == 5'd26 || opc == 5'd27) begin
      add(rec(4'd4), 1'($urandom_range(0, 1)));
    end else begin
      e = rec(4'd4); e.ill = 1; add(e, 1'($urandom_range(0, 1)));
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs and queue its expected outputs.
  task automatic do_cycle(input exp_t e, input bit rr, input bit mr);
    bus.run_req   = rr;
    bus.mem_ready = mr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int w, input bit rr_after, input int stop);
    int n;
    build(ir, w);
    n = (stop == 0) ? plan.size() : stop;
    bus.IR_Data = ir;
    for (int i = 0; i < n; i++)
      do_cycle(plan[i], (i == plan.size() - 1) ? rr_after : 1'($urandom_range(0, 1)), plan_mr[i]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      do_cycle(rec(4'd0), i == n - 1, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input string nm);
    reset_n = 1'b0;
    #1;
    chk(nm, sample(), rec(4'd0));
    bus.run_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ir;
    logic [4:0]  opc;
    bit          rr;
    bus.run_req   = 1'b0;
    bus.mem_ready = 1'b0;
    bus.IR_Data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", sample(), rec(4'd0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(3);

    run_instr(32'h8898_0000, 0, 1'b1, 0);   // neg R1,R3
    run_instr(32'h1891_8000, 0, 1'b1, 0);   // add R1,R2,R3
    run_instr(32'h1891_8000, 3, 1'b1, 0);   // same with 3 memory wait cycles
    run_instr(32'h78A1_0000, 1, 1'b1, 0);   // mul
    run_instr(32'hF800_0000, 0, 1'b1, 0);   // undefined opcode 11111
    run_instr(32'hD000_0000, 0, 1'b0, 0);   // nop, then stop at boundary
    idle_cycles(2);
    run_instr(32'h1891_8000, 2, 1'b0, 0);   // add, stop at T5 boundary
    idle_cycles(1);

    // Asynchronous reset in the middle of T4 clears everything immediately.
    run_instr(32'h1891_8000, 0, 1'b1, 4);
    sb.push_back(plan[4]);
    @(negedge clk);
    #1;
    do_reset("t4_reset");
    idle_cycles(2);

    for (int k = 0; k < 40; k++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd27) opc = 5'd26;
      ir = {opc, 27'($urandom)};
      rr = ($urandom_range(0, 3) != 0);
      run_instr(ir, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : 0, rr, 0);
      if (!rr) idle_cycles(int'($urandom_range(1, 3)));
    end

    run_instr(32'hD800_0000, 0, 1'b0, 0);   // halt
    for (int i = 0; i < 5; i++)
      do_cycle(rec(4'd8), i[0], 1'($urandom_range(0, 1)));
    do_reset("halt_reset");
    idle_cycles(2);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d required=0 pending", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
